// File: rtl/kd_tree_pkg.sv
// Shared KD-tree constants and types: node config word layout and config-loader FSM states.
package kd_tree_pkg;

    localparam int COMP_WIDTH    = 11;
    localparam int NUM_COMPS     = 5;
    localparam int STORAGE_WIDTH = 22;
    localparam int DATA_WIDTH    = COMP_WIDTH * NUM_COMPS;

    typedef struct packed {
        logic signed [COMP_WIDTH-1:0] median;
        logic        [COMP_WIDTH-1:0] index;
    } node_cfg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/node_wen_decoder.sv
// Node write-enable decoder: node_cnt + enable -> one-hot NUM_NODES vector.
// Latency: combinational. Backpressure: none.
module node_wen_decoder #(
    parameter int NUM_NODES = 31,
    parameter int CNT_W     = $clog2(NUM_NODES)
) (
    input  logic [CNT_W-1:0]     node_cnt,
    input  logic                 enable,
    output logic [NUM_NODES-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            onehot[i] = enable && (node_cnt == CNT_W'(i));
        end
    end

endmodule

// File: rtl/kd_node_cfg_loader.sv
// Streams {median,index} words into KD-tree nodes 0..NUM_NODES-1 as one-hot wen pulses.
// Latency: accept -> wen/wdata next cycle; 1 word/cycle. Optional index check: NODE_CFG_RANGE_CHECK_EN.
module kd_node_cfg_loader
    import kd_tree_pkg::*;
#(
    parameter int NUM_NODES = 31
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [STORAGE_WIDTH-1:0] in_data,
    output logic [NUM_NODES-1:0]     wen,
    output logic [STORAGE_WIDTH-1:0] wdata,
    output logic                     busy,
    output logic                     load_done,
    output logic                     cfg_err
);

    localparam int CNT_W = $clog2(NUM_NODES);

    loader_state_t      state;
    logic [CNT_W-1:0]   node_cnt;
    node_cfg_t          cfg;
    logic               accept;
    logic               wr_en;
    logic [NUM_NODES-1:0] dec_wen;

    assign cfg    = node_cfg_t'(in_data);
    // abort wins over an offered word even though in_ready is still high that cycle
    assign accept = (state == LOAD) && in_valid && in_ready && !abort;

`ifdef NODE_CFG_RANGE_CHECK_EN
    logic idx_ok;
    assign idx_ok = cfg.index < COMP_WIDTH'(NUM_COMPS);
    assign wr_en  = accept && idx_ok;
`else
    assign wr_en  = accept;
`endif

    node_wen_decoder #(
        .NUM_NODES (NUM_NODES),
        .CNT_W     (CNT_W)
    ) u_dec (
        .node_cnt (node_cnt),
        .enable   (wr_en),
        .onehot   (dec_wen)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            node_cnt  <= '0;
            wen       <= '0;
            wdata     <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            wen <= '0;
            if (abort) begin
                state     <= IDLE;
                in_ready  <= 1'b0;
                busy      <= 1'b0;
                load_done <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state     <= LOAD;
                            node_cnt  <= '0;
                            load_done <= 1'b0;
                            cfg_err   <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (accept) begin
                            wen   <= dec_wen;
                            wdata <= cfg;
`ifdef NODE_CFG_RANGE_CHECK_EN
                            if (!idx_ok) cfg_err <= 1'b1;
`endif
                            // node_cnt saturates on the last node; DRAIN carries its pulse
                            if (node_cnt == CNT_W'(NUM_NODES - 1)) begin
                                state    <= DRAIN;
                                in_ready <= 1'b0;
                            end else begin
                                node_cnt <= node_cnt + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        load_done <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kd_node_cfg_loader.sv
// Directed self-checking bench for kd_node_cfg_loader (expectations follow NODE_CFG_RANGE_CHECK_EN).
module tb_kd_node_cfg_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, in_valid;
    logic        in_ready;
    logic [21:0] in_data;
    logic [30:0] wen;
    logic [21:0] wdata;
    logic        busy, load_done, cfg_err;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    kd_node_cfg_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .wen       (wen),
        .wdata     (wdata),
        .busy      (busy),
        .load_done (load_done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ready", 64'(in_ready), 64'd1);
        check("start_busy", 64'(busy), 64'd1);
        check("start_done_clr", 64'(load_done), 64'd0);
    endtask

    function automatic logic [21:0] word(input int med, input int idx);
        logic [10:0] m, ix;
        m  = 11'(med);
        ix = 11'(idx);
        return {m, ix};
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        #12;
        check("rst_wen", 64'(wen), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_err", 64'(cfg_err), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: valid without start is ignored
        in_valid = 1'b1; in_data = word(5, 1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_ready", 64'(in_ready), 64'd0);
            check("idle_wen", 64'(wen), 64'd0);
            check("idle_done", 64'(load_done), 64'd0);
        end
        in_valid = 1'b0;

        // 2: back-to-back full load
        do_start();
        for (int k = 0; k < 31; k++) begin
            in_valid = 1'b1; in_data = word(k, k % 5);
            tick();
            check("b2b_wen", 64'(wen), 64'(31'd1 << k));
            check("b2b_wdata", 64'(wdata), 64'(word(k, k % 5)));
            check("b2b_ready", 64'(in_ready), (k == 30) ? 64'd0 : 64'd1);
            check("b2b_busy", 64'(busy), 64'd1);
            check("b2b_done_low", 64'(load_done), 64'd0);
        end
        in_valid = 1'b0;
        tick();
        check("b2b_done", 64'(load_done), 64'd1);
        check("b2b_drain_1cyc", 64'(busy), 64'd0);
        check("b2b_wen_off", 64'(wen), 64'd0);
        in_valid = 1'b1;
        tick();
        check("done_ignores_valid", 64'(wen), 64'd0);
        check("done_held", 64'(load_done), 64'd1);
        in_valid = 1'b0;

        // 3: gapped load, with a start pulse mid-load that must be ignored
        do_start();
        pulses = 0;
        for (int k = 0; k < 31; k++) begin
            in_valid = 1'b1; in_data = word(100 + k, (k + 2) % 5);
            tick();
            pulses += $countones(wen);
            check("gap_wen", 64'(wen), 64'(31'd1 << k));
            check("gap_wdata", 64'(wdata), 64'(word(100 + k, (k + 2) % 5)));
            in_valid = 1'b0;
            start = (k == 12);
            tick();
            start = 1'b0;
            pulses += $countones(wen);
            check("gap_idle_wen", 64'(wen), 64'd0);
            if (k == 30) check("gap_done", 64'(load_done), 64'd1);
            else         check("gap_hold_wdata", 64'(wdata), 64'(word(100 + k, (k + 2) % 5)));
        end
        check("gap_pulses", 64'(pulses), 64'd31);

        // 4: abort after 10 accepts; word offered in abort cycle is dropped
        do_start();
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = word(k, 0);
            tick();
        end
        check("pre_abort_wen", 64'(wen), 64'(31'd1 << 9));
        abort = 1'b1; start = 1'b1; in_data = word(77, 1);
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_wen", 64'(wen), 64'd0);
        check("abort_ready", 64'(in_ready), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(load_done), 64'd0);
        tick();
        check("abort_idle_wen", 64'(wen), 64'd0);
        in_valid = 1'b0;
        do_start();
        in_valid = 1'b1; in_data = word(-3, 4);
        tick();
        in_valid = 1'b0;
        check("reload_wen0", 64'(wen), 64'd1);
        check("reload_wdata", 64'(wdata), 64'(word(-3, 4)));

        // 5: bad index on node 3
        abort = 1'b1; tick(); abort = 1'b0;
        do_start();
        for (int k = 0; k < 31; k++) begin
            in_valid = 1'b1; in_data = word(k, (k == 3) ? 7 : 1);
            tick();
`ifdef NODE_CFG_RANGE_CHECK_EN
            check("rc_wen", 64'(wen), (k == 3) ? 64'd0 : 64'(31'd1 << k));
            check("rc_err", 64'(cfg_err), (k >= 3) ? 64'd1 : 64'd0);
`else
            check("rc_wen", 64'(wen), 64'(31'd1 << k));
            check("rc_err", 64'(cfg_err), 64'd0);
`endif
        end
        in_valid = 1'b0;
        tick();
        check("rc_done", 64'(load_done), 64'd1);
`ifdef NODE_CFG_RANGE_CHECK_EN
        check("rc_err_sticky", 64'(cfg_err), 64'd1);
`else
        check("rc_err_sticky", 64'(cfg_err), 64'd0);
`endif
        do_start();
        check("rc_err_clr", 64'(cfg_err), 64'd0);

        // 6: async reset mid-load at node 15
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_data = word(200 + k, 2);
            tick();
        end
        check("mid_wen15", 64'(wen), 64'(31'd1 << 15));
        rst_n = 1'b0;
        #1;
        check("arst_wen", 64'(wen), 64'd0);
        check("arst_wdata", 64'(wdata), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        in_valid = 1'b1; in_data = word(9, 3);
        tick();
        in_valid = 1'b0;
        check("arst_reload_wen0", 64'(wen), 64'd1);
        check("arst_reload_wdata", 64'(wdata), 64'(word(9, 3)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
